// File: rtl/dram_port_arbiter_if.sv
// Requester-side bundle for one pipeline port of the DRAM arbiter.
// master = pipeline MEM stage, slave = arbiter.
interface dram_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 12
);
    logic          req;
    logic          r_w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, r_w, addr, wdata, input ack, rdata);
    modport slave  (input req, r_w, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dram_port_arbiter.sv
// Two-port req/ack arbiter onto a single-port data RAM.
// Every transaction costs IDLE -> ACCESS -> RESP, and all outputs are registered.
module dram_port_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 12,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_port_arbiter_if.slave   p1,
    dram_port_arbiter_if.slave   p2,
    output logic                 ram_cs,
    output logic                 ram_r_w,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_reg;
    logic          gnt_reg;    // 0 = port 1, 1 = port 2
    logic          last_reg;   // port served most recently, same encoding
    logic          ram_cs_reg;
    logic          ram_r_w_reg;
    logic [AW-1:0] ram_addr_reg;
    logic [DW-1:0] ram_wdata_reg;
    logic [DW-1:0] rdata1_reg;
    logic [DW-1:0] rdata2_reg;
    logic          ack1_reg;
    logic          ack2_reg;
    logic          busy_reg;
    logic          pick2;

    // Port 2 wins when alone, or on a tie when port 1 was served last (round-robin only).
    assign pick2 = p2.req && (!p1.req || (!FIXED_PRIO && !last_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= 1'b0;
            last_reg      <= 1'b1;
            ram_cs_reg    <= 1'b0;
            ram_r_w_reg   <= 1'b1;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            rdata1_reg    <= '0;
            rdata2_reg    <= '0;
            ack1_reg      <= 1'b0;
            ack2_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (p1.req || p2.req) begin
                        gnt_reg       <= pick2;
                        ram_r_w_reg   <= pick2 ? p2.r_w   : p1.r_w;
                        ram_addr_reg  <= pick2 ? p2.addr  : p1.addr;
                        ram_wdata_reg <= pick2 ? p2.wdata : p1.wdata;
                        ram_cs_reg    <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_r_w_reg) begin
                        if (gnt_reg) rdata2_reg <= ram_rdata;
                        else         rdata1_reg <= ram_rdata;
                    end
                    ram_cs_reg <= 1'b0;
                    if (gnt_reg) ack2_reg <= 1'b1;
                    else         ack1_reg <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP: begin
                    ack1_reg  <= 1'b0;
                    ack2_reg  <= 1'b0;
                    last_reg  <= gnt_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ram_cs    = ram_cs_reg;
    assign ram_r_w   = ram_r_w_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign busy      = busy_reg;
    assign p1.ack    = ack1_reg;
    assign p1.rdata  = rdata1_reg;
    assign p2.ack    = ack2_reg;
    assign p2.rdata  = rdata2_reg;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance used only for grant-order checks.
module tb_dram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_cs, ram_r_w, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          f_cs, f_r_w, f_busy;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;
    logic [DW-1:0] f_rdata = 32'h0;

    always #5 clk = ~clk;

    dram_port_arbiter_if #(.DW(DW), .AW(AW)) i1 ();
    dram_port_arbiter_if #(.DW(DW), .AW(AW)) i2 ();
    dram_port_arbiter_if #(.DW(DW), .AW(AW)) q1 ();
    dram_port_arbiter_if #(.DW(DW), .AW(AW)) q2 ();

    dram_port_arbiter #(.DW(DW), .AW(AW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .p1(i1.slave), .p2(i2.slave),
        .ram_cs(ram_cs), .ram_r_w(ram_r_w), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy));

    dram_port_arbiter #(.DW(DW), .AW(AW), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .p1(q1.slave), .p2(q2.slave),
        .ram_cs(f_cs), .ram_r_w(f_r_w), .ram_addr(f_addr),
        .ram_wdata(f_wdata), .ram_rdata(f_rdata), .busy(f_busy));

    // RAM macro model: combinational read, write commits at the edge ending ACCESS.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    assign ram_rdata = (ram_cs && ram_r_w) ? mem[ram_addr] : '0;
    always @(posedge clk) if (ram_cs && !ram_r_w) mem[ram_addr] <= ram_wdata;

    typedef struct {
        int            port;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cs_cnt   = 0;
    logic          cs_rw;
    logic [AW-1:0] cs_addr;
    logic [DW-1:0] cs_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Output monitor: records RAM strobes and pops the scoreboard on every ACK.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (ram_cs) begin
            cs_cnt++;
            cs_rw    = ram_r_w;
            cs_addr  = ram_addr;
            cs_wdata = ram_wdata;
        end
        if (i1.ack || i2.ack) begin
            check("ack_overlap", {31'b0, i1.ack & i2.ack}, 32'd0);
            check("busy_in_resp", {31'b0, busy}, 32'd1);
            p = i1.ack ? 1 : 2;
            if (exp_q.size() == 0) begin
                check("unexpected_ack", p, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", p, e.port);
                if (e.rd) check("rdata", (p == 1) ? i1.rdata : i2.rdata, e.data);
                $display("txn port=%0d %s data=%h", p, e.rd ? "RD" : "WR", e.data);
            end
        end
    end

    task automatic set_port(input int port, input bit req, input bit rd,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 1) begin
            i1.req = req; i1.r_w = rd; i1.addr = a; i1.wdata = d;
        end else begin
            i2.req = req; i2.r_w = rd; i2.addr = a; i2.wdata = d;
        end
    endtask

    task automatic push_exp(input int port, input bit rd,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.data = rd ? shadow[a] : d;
        if (!rd) shadow[a] = d;
        exp_q.push_back(e);
    endtask

    // Single transaction from an idle arbiter; called just after a rising edge.
    task automatic txn(input int port, input bit rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        int base, cyc;
        bit got;
        push_exp(port, rd, a, d);
        base = cs_cnt;
        set_port(port, 1'b1, rd, a, d);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            got = (port == 1) ? i1.ack : i2.ack;
        end
        check("ack_latency", cyc, 2);
        set_port(port, 1'b0, rd, a, d);
        check("cs_cycles", cs_cnt - base, 1);
        check("cs_op", {31'b0, cs_rw}, {31'b0, rd});
        check("cs_addr", {20'b0, cs_addr}, {20'b0, a});
        if (!rd) check("cs_wdata", cs_wdata, d);
        @(posedge clk); #1;
    endtask

    initial begin
        int n1, n2, k, acks, cyc;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        set_port(1, 1'b0, 1'b1, '0, '0);
        set_port(2, 1'b0, 1'b1, '0, '0);
        q1.req = 1'b0; q1.r_w = 1'b1; q1.addr = '0; q1.wdata = '0;
        q2.req = 1'b0; q2.r_w = 1'b1; q2.addr = '0; q2.wdata = '0;

        // Reset held: request toggling must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            i1.req = ~i1.req;
            i2.req = (i % 2 == 0);
            check("rst_cs", {31'b0, ram_cs}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_ack", {30'b0, i1.ack, i2.ack}, 32'd0);
        end
        check("rst_r_w", {31'b0, ram_r_w}, 32'd1);
        check("rst_addr", {20'b0, ram_addr}, 32'd0);
        check("rst_rdata1", i1.rdata, 32'd0);
        check("rst_rdata2", i2.rdata, 32'd0);
        check("rst_cs_count", cs_cnt, 0);
        set_port(1, 1'b0, 1'b1, '0, '0);
        set_port(2, 1'b0, 1'b1, '0, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Both ports held from reset: round-robin order 1,2,1,2.
        push_exp(1, 1'b0, 12'h100, 32'hAAAA_0001);
        push_exp(2, 1'b0, 12'h200, 32'hBBBB_0002);
        push_exp(1, 1'b0, 12'h100, 32'hAAAA_0001);
        push_exp(2, 1'b0, 12'h200, 32'hBBBB_0002);
        set_port(1, 1'b1, 1'b0, 12'h100, 32'hAAAA_0001);
        set_port(2, 1'b1, 1'b0, 12'h200, 32'hBBBB_0002);
        acks = 0;
        cyc  = 0;
        while (acks < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (i1.ack || i2.ack) acks++;
        end
        check("rr_ack_count", acks, 4);
        set_port(1, 1'b0, 1'b0, 12'h100, 32'hAAAA_0001);
        set_port(2, 1'b0, 1'b0, 12'h200, 32'hBBBB_0002);
        @(posedge clk); #1;

        // Port 1 write then read back.
        txn(1, 1'b0, 12'h010, 32'hDEAD_BEEF);
        txn(1, 1'b1, 12'h010, 32'h0);
        check("rdata1_after_read", i1.rdata, 32'hDEAD_BEEF);

        // Port 2 write to top address, port 1 reads it; RDATA2 must hold.
        txn(2, 1'b1, 12'h200, 32'h0);
        txn(2, 1'b0, 12'hFFF, 32'h1234_5678);
        txn(1, 1'b1, 12'hFFF, 32'h0);
        check("rdata1_top", i1.rdata, 32'h1234_5678);
        check("rdata2_hold", i2.rdata, 32'hBBBB_0002);

        // Reset pulsed mid-ACCESS of a port 2 read: aborted, no ACK.
        set_port(2, 1'b1, 1'b1, 12'h200, 32'h0);
        @(posedge clk); #1;
        check("cs_in_access", {31'b0, ram_cs}, 32'd1);
        #1 rst_n = 1'b0;
        set_port(2, 1'b0, 1'b1, 12'h200, 32'h0);
        #1;
        check("abort_cs", {31'b0, ram_cs}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {30'b0, i1.ack, i2.ack}, 32'd0);
        end
        txn(1, 1'b1, 12'h100, 32'h0);
        check("queue_empty", exp_q.size(), 0);

        // Fixed priority: port 1 wins every tie, port 2 served once port 1 drops.
        q1.req = 1'b1; q1.addr = 12'h001;
        q2.req = 1'b1; q2.addr = 12'h002;
        n1 = 0; n2 = 0; cyc = 0;
        while (n1 < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (q1.ack) n1++;
            if (q2.ack) n2++;
        end
        check("fixed_p1_grants", n1, 3);
        check("fixed_p2_starved", n2, 0);
        q1.req = 1'b0;
        k = 0;
        while (n2 == 0 && k < 10) begin
            @(posedge clk); #1;
            k++;
            if (q1.ack) n1++;
            if (q2.ack) n2++;
        end
        q2.req = 1'b0;
        check("fixed_p2_after_drop", n2, 1);
        check("fixed_no_extra_p1", n1, 3);
        $display("txn fixed-prio grants p1=%0d p2=%0d", n1, n2);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
